// File: rtl/aes_128_decrypt_iter.sv
// Iterative AES-128 decryption: forward key expansion to round key 10, then ten
// inverse rounds (one per clock) while the key schedule is unrolled backwards.

module gf_inv_byte (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs)
  logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
  assign a2   = gmul(a, a);
  assign a3   = gmul(a2, a);
  assign a6   = gmul(a3, a3);
  assign a12  = gmul(a6, a6);
  assign a15  = gmul(a12, a3);
  assign a30  = gmul(a15, a15);
  assign a60  = gmul(a30, a30);
  assign a120 = gmul(a60, a60);
  assign a240 = gmul(a120, a120);
  assign y    = gmul(gmul(a240, a12), a2);
endmodule

module sbox_byte (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] inv;
  gf_inv_byte u_inv (.a(a), .y(inv));
  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module inv_sbox_byte (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] b;
  assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  gf_inv_byte u_inv (.a(b), .y(y));
endmodule

module aes_128_decrypt_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;

  state_t       state;
  logic [127:0] st;
  logic [127:0] kr;
  logic [3:0]   cnt;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] m2, m4, m8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2    = xt(a[i]);
      m4    = xt(m2);
      m8    = xt(m4);
      m9[i] = m8 ^ a[i];
      mb[i] = m8 ^ m2 ^ a[i];
      md[i] = m8 ^ m4 ^ a[i];
      me[i] = m8 ^ m4 ^ m2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [31:0] w0, w1, w2, w3, w3p;
  assign w0  = kr[127:96];
  assign w1  = kr[95:64];
  assign w2  = kr[63:32];
  assign w3  = kr[31:0];
  assign w3p = w3 ^ w2;

  // The four key-schedule S-boxes serve both directions: w3 forward, w3^w2 backward
  logic        dec_dir;
  logic [31:0] sw_src, rot_word, sub_word;
  logic [7:0]  rc;
  assign dec_dir  = (state == DEC);
  assign sw_src   = dec_dir ? w3p : w3;
  assign rot_word = {sw_src[23:0], sw_src[31:24]};
  assign rc       = rcon(dec_dir ? cnt - 4'd1 : cnt);

  for (genvar gi = 0; gi < 4; gi++) begin : g_ks_sbox
    sbox_byte u_sbox (.a(rot_word[31-8*gi -: 8]), .y(sub_word[31-8*gi -: 8]));
  end

  logic [31:0]  f0, f1, f2, f3;
  logic [127:0] fwd_key, inv_key;
  assign f0      = w0 ^ sub_word ^ {rc, 24'h0};
  assign f1      = w1 ^ f0;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};
  assign inv_key = {w0 ^ sub_word ^ {rc, 24'h0}, w1 ^ w0, w2 ^ w1, w3p};

  // InvShiftRows folded into the S-box input wiring: out[r][c] = in[r][(c-r) mod 4]
  logic [127:0] isb, t, imc;
  for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sub
    localparam int R   = gi % 4;
    localparam int C   = gi / 4;
    localparam int SRC = 4 * ((C - R + 4) % 4) + R;
    inv_sbox_byte u_isbox (.a(st[127-8*SRC -: 8]), .y(isb[127-8*gi -: 8]));
  end

  assign t = isb ^ inv_key;

  for (genvar gi = 0; gi < 4; gi++) begin : g_imc
    assign imc[127-32*gi -: 32] = inv_mix_col(t[127-32*gi -: 32]);
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      st        <= '0;
      kr        <= '0;
      cnt       <= '0;
      pt        <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= ct;
            kr    <= key;
            cnt   <= 4'd0;
            state <= KEXP;
          end
        end
        KEXP: begin
          kr  <= fwd_key;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) begin
            st    <= st ^ fwd_key;
            state <= DEC;
          end
        end
        DEC: begin
          kr  <= inv_key;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            st        <= t;
            pt        <= t;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            st <= imc;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
